// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the product
// accumulator and the downstream consumer of frame sums.
interface product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
);
  logic [PROD_W-1:0] prod;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_overflow;

  // Environment side: supplies products and consumes frame sums.
  modport master (
    output prod, in_valid, out_ready,
    input  in_ready, out_valid, acc_out, out_overflow
  );

  // Accumulator side.
  modport slave (
    input  prod, in_valid, out_ready,
    output in_ready, out_valid, acc_out, out_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Frame-based accumulator for the 4x4 multiplier: sums FRAME_LEN accepted
// products, then holds the sum and a sticky overflow flag on an output
// handshake until the consumer takes it.
module product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus,
  input  logic                  clear,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int               SUM_W    = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum;
  logic               accept;

  // State register and datapath registers; reset clears any partial frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, accumulate and output decode.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    ovf_d            = ovf_q;
    cnt_d            = cnt_q;
    accept           = bus.in_valid && (state_q != DONE);
    // Extra top bit captures the carry out of the accumulator.
    sum              = {1'b0, acc_q} + SUM_W'(bus.prod);

    bus.in_ready     = (state_q != DONE);
    bus.out_valid    = (state_q == DONE);
    busy             = (state_q == ACCUM);
    bus.acc_out      = acc_q;
    bus.out_overflow = ovf_q;

    if (clear) begin
      // Abort wins over both accept and output handshake.
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          // prod only reaches the registers on an accept, so an undriven
          // bus while in_valid is low never leaks into the sum.
          if (accept) begin
            acc_d   = sum[ACC_W-1:0];
            ovf_d   = ovf_q | sum[ACC_W];
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST_IDX) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (default, 9-bit accumulator,
// single-product frames) share one stimulus stream; a behavioural model of
// each frame is compared against the outputs every cycle.
module tb_product_accumulator;

  localparam int N = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] prod_s      = '0;
  logic       in_valid_s  = 1'b0;
  logic       out_ready_s = 1'b0;
  logic       clear_s     = 1'b0;
  logic       cmp_en      = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if0 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(9))  if1 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if2 ();

  assign if0.prod = prod_s;  assign if0.in_valid = in_valid_s;  assign if0.out_ready = out_ready_s;
  assign if1.prod = prod_s;  assign if1.in_valid = in_valid_s;  assign if1.out_ready = out_ready_s;
  assign if2.prod = prod_s;  assign if2.in_valid = in_valid_s;  assign if2.out_ready = out_ready_s;

  logic busy0, busy1, busy2;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .clear(clear_s), .busy(busy0));
  product_accumulator #(.PROD_W(8), .ACC_W(9), .FRAME_LEN(4), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .clear(clear_s), .busy(busy1));
  product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .clear(clear_s), .busy(busy2));

  // Uniform views of the three instances.
  logic [15:0] acc_o [N];
  logic        ovf_o [N];
  logic        ov_o  [N];
  logic        ir_o  [N];
  logic        bz_o  [N];

  assign acc_o[0] = if0.acc_out;          assign acc_o[1] = {7'b0, if1.acc_out}; assign acc_o[2] = if2.acc_out;
  assign ovf_o[0] = if0.out_overflow;     assign ovf_o[1] = if1.out_overflow;    assign ovf_o[2] = if2.out_overflow;
  assign ov_o[0]  = if0.out_valid;        assign ov_o[1]  = if1.out_valid;       assign ov_o[2]  = if2.out_valid;
  assign ir_o[0]  = if0.in_ready;         assign ir_o[1]  = if1.in_ready;        assign ir_o[2]  = if2.in_ready;
  assign bz_o[0]  = busy0;                assign bz_o[1]  = busy1;               assign bz_o[2]  = busy2;

  function automatic int frame_len(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int acc_w(int i);
    return (i == 1) ? 9 : 16;
  endfunction

  // Model: true (unbounded) sum of the products accepted in the current
  // frame, how many were accepted, and whether the frame is complete.
  longint m_sum  [N];
  int     m_n    [N];
  bit     m_done [N];

  function automatic logic [15:0] exp_acc(int i);
    return 16'(m_sum[i] % (longint'(1) << acc_w(i)));
  endfunction

  function automatic logic exp_ovf(int i);
    return m_sum[i] >= (longint'(1) << acc_w(i));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n || clear_s) begin
        m_sum[i]  <= 0;
        m_n[i]    <= 0;
        m_done[i] <= 1'b0;
      end else if (m_done[i]) begin
        if (out_ready_s) begin
          m_sum[i]  <= 0;
          m_n[i]    <= 0;
          m_done[i] <= 1'b0;
        end
      end else if (in_valid_s) begin
        m_sum[i]  <= m_sum[i] + longint'(prod_s);
        m_n[i]    <= m_n[i] + 1;
        m_done[i] <= (m_n[i] + 1 == frame_len(i));
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("u%0d.acc_out", i),      32'(acc_o[i]), 32'(exp_acc(i)));
        check($sformatf("u%0d.out_overflow", i), 32'(ovf_o[i]), 32'(exp_ovf(i)));
        check($sformatf("u%0d.out_valid", i),    32'(ov_o[i]),  32'(m_done[i]));
        check($sformatf("u%0d.in_ready", i),     32'(ir_o[i]),  32'(!m_done[i]));
        check($sformatf("u%0d.busy", i),         32'(bz_o[i]),  32'(!m_done[i] && m_n[i] > 0));
      end
    end
  end

  // Present one cycle of inputs, then return just after the edge.
  task automatic step(bit v, logic [7:0] p, bit c, bit r);
    in_valid_s  = v;
    prod_s      = p;
    clear_s     = c;
    out_ready_s = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] gap_prods [4];
    gap_prods = '{8'd36, 8'd0, 8'd81, 8'd6};

    // Reset values, observed before any clock edge has passed.
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset u%0d in_ready", i),  32'(ir_o[i]),  32'd1);
      check($sformatf("reset u%0d out_valid", i), 32'(ov_o[i]),  32'd0);
      check($sformatf("reset u%0d acc_out", i),   32'(acc_o[i]), 32'd0);
      check($sformatf("reset u%0d busy", i),      32'(bz_o[i]),  32'd0);
    end
    #10;
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame: 4 x 225.
    repeat (4) step(1'b1, 8'd225, 1'b0, 1'b1);
    check("basic u0 out_valid", 32'(ov_o[0]),  32'd1);
    check("basic u0 acc_out",   32'(acc_o[0]), 32'd900);
    check("basic u0 overflow",  32'(ovf_o[0]), 32'd0);
    check("basic u0 in_ready",  32'(ir_o[0]),  32'd0);
    check("ovf u1 acc_out",     32'(acc_o[1]), 32'd388);
    check("ovf u1 overflow",    32'(ovf_o[1]), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    check("basic u0 idle valid", 32'(ov_o[0]),  32'd0);
    check("basic u0 idle acc",   32'(acc_o[0]), 32'd0);

    // Gapped input, then backpressure with a product offered in DONE.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, gap_prods[k], 1'b0, 1'b0);
      if (k < 3) repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0);
    end
    check("gap u0 out_valid", 32'(ov_o[0]),  32'd1);
    check("gap u0 acc_out",   32'(acc_o[0]), 32'd123);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'd200, 1'b0, 1'b0);
      check("hold u0 acc_out",   32'(acc_o[0]), 32'd123);
      check("hold u0 in_ready",  32'(ir_o[0]),  32'd0);
      check("hold u0 out_valid", 32'(ov_o[0]),  32'd1);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
    check("gap u0 released", 32'(ov_o[0]), 32'd0);

    // Frame after an overflowing one starts clean.
    repeat (4) step(1'b1, 8'd1, 1'b0, 1'b0);
    check("ovf u1 next acc",   32'(acc_o[1]), 32'd4);
    check("ovf u1 next flag",  32'(ovf_o[1]), 32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Clear mid-frame drops the product offered with it.
    repeat (2) step(1'b1, 8'd100, 1'b0, 1'b1);
    check("clr u0 partial",  32'(acc_o[0]), 32'd200);
    check("clr u0 busy",     32'(bz_o[0]),  32'd1);
    step(1'b1, 8'd50, 1'b1, 1'b1);
    check("clr u0 busy off", 32'(bz_o[0]),  32'd0);
    check("clr u0 acc",      32'(acc_o[0]), 32'd0);
    repeat (4) step(1'b1, 8'd10, 1'b0, 1'b0);
    check("clr u0 sum",      32'(acc_o[0]), 32'd40);
    check("clr u0 valid",    32'(ov_o[0]),  32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    repeat (3) step(1'b1, 8'd7, 1'b0, 1'b1);
    check("arst u0 partial", 32'(acc_o[0]), 32'd21);
    pulse_reset();
    check("arst u0 acc",      32'(acc_o[0]), 32'd0);
    check("arst u0 busy",     32'(bz_o[0]),  32'd0);
    check("arst u0 in_ready", 32'(ir_o[0]),  32'd1);
    release_reset();

    // Asynchronous reset while a result is held.
    repeat (4) step(1'b1, 8'd9, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("arst2 u0 held", 32'(acc_o[0]), 32'd36);
    pulse_reset();
    check("arst2 u0 valid", 32'(ov_o[0]),  32'd0);
    check("arst2 u0 acc",   32'(acc_o[0]), 32'd0);
    release_reset();
    repeat (4) step(1'b1, 8'd5, 1'b0, 1'b0);
    check("arst2 u0 fresh", 32'(acc_o[0]), 32'd20);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Single-product frames: one result every two cycles.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'd49, 1'b0, 1'b1);
      check("f1 u2 valid", 32'(ov_o[2]),  (k % 2 == 0) ? 32'd1 : 32'd0);
      check("f1 u2 acc",   32'(acc_o[2]), (k % 2 == 0) ? 32'd49 : 32'd0);
      check("f1 u2 busy",  32'(bz_o[2]),  32'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
    end

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 combinational multiplier.
- Takes the 8-bit product P7..P0 under a valid/ready handshake and sums FRAME_LEN consecutive products into a wide accumulator.
- Presents each frame sum on a held output handshake, with a sticky overflow flag.
- Turns the free-running multiplier into a frame-based multiply-accumulate path for dot-product use.

Parameters:
- PROD_W, 8: product width; matches the multiplier's P0..P7 output.
- ACC_W, 16: accumulator and result width; must be >= PROD_W.
- FRAME_LEN, 4: number of products summed per frame, range 1..255.
- CNT_W, 8: width of the term counter; must hold FRAME_LEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- prod  in  PROD_W  product from the multiplier; bit i = Pi
- in_valid  in  1  prod is valid this cycle
- in_ready  out  1  block accepts prod this cycle
- clear  in  1  synchronous abort: discard the partial or held frame
- out_valid  out  1  acc_out and out_overflow hold a completed frame
- out_ready  in  1  downstream accepts the result
- acc_out  out  ACC_W  frame sum, modulo 2^ACC_W
- out_overflow  out  1  a carry out of ACC_W occurred during this frame (sticky per frame)
- busy  out  1  a frame is in progress (state ACCUM)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Accumulator = 0, count = 0, overflow = 0.
  - out_valid = 0, acc_out = 0, out_overflow = 0, busy = 0, in_ready = 1 (in_ready is driven by the combinational decode of IDLE).
  - Reset mid-frame discards all partial data. No output until a complete new frame is accepted.
- State machine: IDLE, ACCUM, DONE.
  - in_ready = 1 in IDLE and ACCUM, 0 in DONE.
  - busy = 1 only in ACCUM.
  - out_valid = 1 only in DONE.
- Accept event: in_valid & in_ready at a rising edge.
  - acc <= acc + zero-extended prod.
  - overflow <= overflow | carry out of bit ACC_W-1.
  - count <= count + 1.
- Transitions:
  - IDLE -> ACCUM on an accept, when FRAME_LEN > 1.
  - IDLE or ACCUM -> DONE on the accept that makes count equal FRAME_LEN. This includes IDLE -> DONE directly when FRAME_LEN = 1.
  - DONE -> IDLE on out_valid & out_ready. In the same edge, acc, count and overflow clear to 0.
  - No accept is possible in DONE, so nothing is lost on the DONE-exit cycle.
- Latency: out_valid rises on the edge that accepts the FRAME_LEN-th product, i.e. it is visible the cycle after that product is presented.
- Gaps in in_valid are allowed. The state holds, and acc/count are unchanged.
- Output hold: in DONE, acc_out and out_overflow stay stable until the handshake, however long out_ready stays low.
- clear: takes priority over accept and output handshake in every state.
  - Next state IDLE; acc, count and overflow = 0; out_valid = 0.
  - A product presented in the clear cycle is dropped, although in_ready may read 1.
- Arithmetic: unsigned. acc_out wraps modulo 2^ACC_W. The overflow flag records any wrap within the frame and never self-clears mid-frame.
- prod is never registered outside an accept. X on prod while in_valid = 0 must not propagate.

Test Plan:
- Basic frame (defaults): after reset, 4 accepts of prod = 225 (15x15) on consecutive cycles -> out_valid = 1 the cycle after the 4th; acc_out = 900 (0x0384), out_overflow = 0; in_ready = 0 while DONE; with out_ready = 1, back to IDLE with acc = 0 next cycle.
- Gapped input and backpressure: prods 36, 0, 81, 6 with 2 idle cycles between each; out_ready held low 5 cycles -> acc_out = 123 held stable for all 5 cycles, in_ready = 0 throughout; the handshake on cycle 6 returns to IDLE.
- Overflow (ACC_W = 9): 4 x prod = 225 -> acc_out = 388 (900 mod 512), out_overflow = 1; the next frame of 4 x 1 -> acc_out = 4, out_overflow = 0.
- clear mid-frame: accept 2 x 100, then clear with in_valid = 1 and prod = 50 in the same cycle -> IDLE, busy = 0; the following 4 x 10 give acc_out = 40 (the 50 is dropped).
- Async reset mid-frame and in DONE: assert rst_n low between clock edges after 3 accepts -> all outputs go to reset values immediately, without waiting for a clock edge; repeat with rst_n low while DONE and out_ready = 0 -> out_valid drops at once and the next frame sums from 0.
- FRAME_LEN = 1: each accept of prod = 49 -> IDLE to DONE directly, acc_out = 49, busy never asserts; back-to-back frames run at one result per 2 cycles with out_ready = 1.
